// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a show-ahead receive FIFO.
// Define UART_RX_ERR_TAG_EN to keep errored frames as tagged FIFO entries.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 10_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
`ifdef UART_RX_ERR_TAG_EN
   output logic [DATA_BITS+1:0]          out_data,
`else
   output logic [DATA_BITS-1:0]          out_data,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
   localparam int TW        = $clog2(BIT_TICKS);
   localparam int NW        = $clog2(DATA_BITS);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
`ifdef UART_RX_ERR_TAG_EN
   localparam int OW        = DATA_BITS + 2;
`else
   localparam int OW        = DATA_BITS;
`endif

   localparam logic [TW-1:0] T_FULL = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] T_HALF = TW'(BIT_TICKS / 2 - 1);

   if (BIT_TICKS < 4) begin : g_chk_baud
      $error("uart_rx_fifo: BIT_TICKS must be at least 4");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
      $error("uart_rx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_chk_par
      $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e               state_q, state_d;
   logic                 rx_meta_q, rxs_q, rxs_prev_q;
   logic [TW-1:0]        timer_q, timer_d;
   logic [NW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ppls_q, ppls_d;
   logic                 fall, tick;
   logic                 push;
   logic [OW-1:0]        push_word;

   logic [OW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [CW-1:0]        count_q, count_d;
   logic                 ovf_q;
   logic                 full, pop, wr_en, ovf_set;

   assign fall = !rxs_q && rxs_prev_q;
   assign tick = (timer_q == '0);

   // Two-flop rx synchroniser plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         cnt_q   <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ppls_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ppls_q  <= ppls_d;
      end
   end

   // Frame FSM: bit-centre sampling, parity/stop checks, push request
   always_comb begin
      state_d   = state_q;
      timer_d   = tick ? timer_q : timer_q - 1'b1;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      perr_d    = perr_q;
      ferr_d    = 1'b0;
      ppls_d    = 1'b0;
      push      = 1'b0;
      push_word = '0;
      unique case (state_q)
         S_IDLE: begin
            if (fall) begin
               timer_d = T_HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (!rxs_q) begin
                  timer_d = T_FULL;
                  cnt_d   = '0;
                  perr_d  = 1'b0;
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d[cnt_q] = rxs_q;
               timer_d        = T_FULL;
               if (cnt_q == NW'(DATA_BITS - 1)) begin
                  cnt_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               perr_d  = (^shreg_q) ^ rxs_q ^ (PARITY == 1);
               timer_d = T_FULL;
               cnt_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               timer_d = T_FULL;
               if (!rxs_q) begin
                  ferr_d  = 1'b1;
                  state_d = S_IDLE;
`ifdef UART_RX_ERR_TAG_EN
                  push      = 1'b1;
                  push_word = {1'b1, perr_q, shreg_q};
`endif
               end else if (cnt_q == NW'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  ppls_d  = perr_q;
`ifdef UART_RX_ERR_TAG_EN
                  push      = 1'b1;
                  push_word = {1'b0, perr_q, shreg_q};
`else
                  push      = !perr_q;
                  push_word = shreg_q;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign pop     = out_valid && out_ready;
   assign wr_en   = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   // Occupancy follows push/pop; simultaneous push and pop cancel
   always_comb begin
      count_d = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, pointers and sticky overflow (set beats clear)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wptr_q] <= push_word;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         count_q <= count_d;
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (clr_overflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign out_data   = mem_q[rptr_q];
   assign out_valid  = (count_q != '0);
   assign fifo_count = count_q;
   assign frame_err  = ferr_q;
   assign parity_err = ppls_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo (8N1 and 8E1 instances).
// Build with UART_RX_ERR_TAG_EN to exercise tagged error entries.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int BT = 86;
   localparam int DW = 8;
`ifdef UART_RX_ERR_TAG_EN
   localparam int OW = DW + 2;
`else
   localparam int OW = DW;
`endif

   logic          clk = 1'b0;
   logic          rst, rx, rx_p;
   logic          out_ready, ready_p, clr, clr_p;
   logic [OW-1:0] out_data, data_p;
   logic          out_valid, valid_p;
   logic [4:0]    cnt, cnt_p;
   logic          fe, pe, ovf, fe_p, pe_p, ovf_p;

   int      checks = 0;
   int      errors = 0;
   int      fe_n = 0, pe_n = 0, fe_np = 0, pe_np = 0;
   longint  cyc = 0;
   longint  rise_cyc = 0;
   longint  start_cyc = 0;
   logic    prev_v = 1'b0;
   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] exp_pq[$];
   logic [OW-1:0] ev, evp;

   always #50 clk = ~clk;

   uart_rx_fifo dut (
      .clk(clk), .rst(rst), .rx(rx),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_count(cnt), .frame_err(fe), .parity_err(pe),
      .overflow(ovf), .clr_overflow(clr)
   );

   uart_rx_fifo #(.PARITY(2)) dut_p (
      .clk(clk), .rst(rst), .rx(rx_p),
      .out_data(data_p), .out_valid(valid_p), .out_ready(ready_p),
      .fifo_count(cnt_p), .frame_err(fe_p), .parity_err(pe_p),
      .overflow(ovf_p), .clr_overflow(clr_p)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fe)   fe_n  <= fe_n + 1;
      if (pe)   pe_n  <= pe_n + 1;
      if (fe_p) fe_np <= fe_np + 1;
      if (pe_p) pe_np <= pe_np + 1;
      if (out_valid && !prev_v) rise_cyc <= cyc;
      prev_v <= out_valid;
   end

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got %h want none", out_data);
         end else begin
            ev = exp_q.pop_front();
            if (out_data !== ev) begin
               errors++;
               $display("FAIL pop_data got %h want %h", out_data, ev);
            end
         end
      end
      if (rst && valid_p && ready_p) begin
         checks++;
         if (exp_pq.size() == 0) begin
            errors++;
            $display("FAIL popp_unexpected got %h want none", data_p);
         end else begin
            evp = exp_pq.pop_front();
            if (data_p !== evp) begin
               errors++;
               $display("FAIL popp_data got %h want %h", data_p, evp);
            end
         end
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic line(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx   = v;
      repeat (BT) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d,
                             input int pbit, input bit stop_ok,
                             input bit room);
      bit perr;
      logic [OW-1:0] e;
      perr = (pbit >= 0) && ((^d) ^ pbit[0]);
`ifdef UART_RX_ERR_TAG_EN
      e = {~stop_ok, perr, d};
      if (room) begin
`else
      e = d;
      if (room && stop_ok && !perr) begin
`endif
         if (sel) exp_pq.push_back(e);
         else     exp_q.push_back(e);
      end
      @(negedge clk);
      start_cyc = cyc;
      line(sel, 1'b0);
      for (int i = 0; i < 8; i++) line(sel, d[i]);
      if (pbit >= 0) line(sel, pbit[0]);
      line(sel, stop_ok);
      if (!stop_ok) line(sel, 1'b1);
   endtask

   task automatic drain(input bit sel, output bit done);
      int g;
      g = 0;
      @(posedge clk); #1;
      if (sel) ready_p = 1'b1;
      else     out_ready = 1'b1;
      while (g < 100 && (sel ? exp_pq.size() : exp_q.size()) != 0) begin
         @(posedge clk); #1;
         g++;
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      ready_p   = 1'b0;
      done = ((sel ? exp_pq.size() : exp_q.size()) == 0);
   endtask

   task automatic test_reset;
      rst = 1'b0; rx = 1'b1; rx_p = 1'b1;
      out_ready = 1'b0; ready_p = 1'b0; clr = 1'b0; clr_p = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== '0) begin
         errors++; $display("FAIL rst_data got %h want 0", out_data);
      end
      checks++;
      if (cnt !== 5'd0) begin
         errors++; $display("FAIL rst_count got %0d want 0", cnt);
      end
      checks++;
      if ({fe, pe, ovf} !== 3'b000) begin
         errors++; $display("FAIL rst_errs got %b want 000", {fe, pe, ovf});
      end
      checks++;
      if ({valid_p, cnt_p} !== 6'd0) begin
         errors++; $display("FAIL rst_p got %b want 0", {valid_p, cnt_p});
      end
      rst = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic;
      int f0, p0;
      longint lat;
      bit done;
      f0 = fe_n; p0 = pe_n;
      send_frame(1'b0, 8'hA5, -1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      lat = rise_cyc - start_cyc;
      checks++;
      if (lat < 818 || lat > 822) begin
         errors++; $display("FAIL basic_latency got %0d want 818..822", lat);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== OW'(8'hA5)) begin
         errors++;
         $display("FAIL basic_head got %b/%h want 1/a5", out_valid, out_data);
      end
      checks++;
      if (cnt !== 5'd1) begin
         errors++; $display("FAIL basic_count got %0d want 1", cnt);
      end
      checks++;
      if (fe_n != f0 || pe_n != p0) begin
         errors++; $display("FAIL basic_pulses got %0d/%0d want 0/0",
                            fe_n - f0, pe_n - p0);
      end
      drain(1'b0, done);
      checks++;
      if (!done || cnt !== 5'd0) begin
         errors++; $display("FAIL basic_drain got %0d left want 0", cnt);
      end
   endtask

   task automatic test_overflow;
      bit done;
      for (int b = 0; b < 17; b++) begin
         send_frame(1'b0, 8'(b), -1, 1'b1, b < 16);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (cnt !== 5'd16) begin
         errors++; $display("FAIL ovf_count got %0d want 16", cnt);
      end
      checks++;
      if (ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_set got %b want 1", ovf);
      end
      drain(1'b0, done);
      checks++;
      if (!done) begin
         errors++; $display("FAIL ovf_drain got %0d left want 0", exp_q.size());
      end
      @(negedge clk);
      checks++;
      if (ovf !== 1'b1 || cnt !== 5'd0) begin
         errors++; $display("FAIL ovf_sticky got %b/%0d want 1/0", ovf, cnt);
      end
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear got %b want 0", ovf);
      end
   endtask

   task automatic test_parity;
      int p0;
      bit done;
      p0 = pe_np;
      send_frame(1'b1, 8'h03, 1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checks++;
      if (pe_np != p0 + 1) begin
         errors++; $display("FAIL par_pulse got %0d want 1", pe_np - p0);
      end
      checks++;
`ifdef UART_RX_ERR_TAG_EN
      if (cnt_p !== 5'd1) begin
         errors++; $display("FAIL par_count got %0d want 1", cnt_p);
      end
`else
      if (cnt_p !== 5'd0) begin
         errors++; $display("FAIL par_count got %0d want 0", cnt_p);
      end
`endif
      send_frame(1'b1, 8'h03, 0, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checks++;
      if (pe_np != p0 + 1) begin
         errors++; $display("FAIL par_good got %0d want 1", pe_np - p0);
      end
      drain(1'b1, done);
      checks++;
      if (!done || cnt_p !== 5'd0) begin
         errors++; $display("FAIL par_drain got %0d left want 0", cnt_p);
      end
   endtask

   task automatic test_break;
      int f0, p0;
      bit done;
      f0 = fe_n; p0 = pe_n;
`ifdef UART_RX_ERR_TAG_EN
      exp_q.push_back({1'b1, 1'b0, 8'h00});
`endif
      @(negedge clk);
      rx = 1'b0;
      repeat (30 * BT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BT) @(negedge clk);
      checks++;
      if (fe_n != f0 + 1 || pe_n != p0) begin
         errors++; $display("FAIL brk_pulses got %0d/%0d want 1/0",
                            fe_n - f0, pe_n - p0);
      end
      checks++;
`ifdef UART_RX_ERR_TAG_EN
      if (cnt !== 5'd1) begin
         errors++; $display("FAIL brk_count got %0d want 1", cnt);
      end
`else
      if (cnt !== 5'd0) begin
         errors++; $display("FAIL brk_count got %0d want 0", cnt);
      end
`endif
      send_frame(1'b0, 8'h5A, -1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      drain(1'b0, done);
      checks++;
      if (!done || fe_n != f0 + 1) begin
         errors++; $display("FAIL brk_next got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_bad_stop;
      int f0;
      bit done;
      f0 = fe_n;
      send_frame(1'b0, 8'h7E, -1, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      checks++;
      if (fe_n != f0 + 1) begin
         errors++; $display("FAIL stop_pulse got %0d want 1", fe_n - f0);
      end
`ifdef UART_RX_ERR_TAG_EN
      checks++;
      if (cnt !== 5'd1 || out_data !== {1'b1, 1'b0, 8'h7E}) begin
         errors++; $display("FAIL stop_tag got %0d/%h want 1/27e", cnt, out_data);
      end
`else
      checks++;
      if (cnt !== 5'd0) begin
         errors++; $display("FAIL stop_count got %0d want 0", cnt);
      end
`endif
      drain(1'b0, done);
      checks++;
      if (!done) begin
         errors++; $display("FAIL stop_drain got %0d left want 0", exp_q.size());
      end
   endtask

   task automatic test_glitch_reset;
      int f0, p0;
      bit done;
      f0 = fe_n; p0 = pe_n;
      @(negedge clk);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      checks++;
      if (fe_n != f0 || pe_n != p0 || cnt !== 5'd0) begin
         errors++; $display("FAIL glitch got %0d/%0d/%0d want 0/0/0",
                            fe_n - f0, pe_n - p0, cnt);
      end
      send_frame(1'b0, 8'h11, -1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checks++;
      if (cnt !== 5'd1) begin
         errors++; $display("FAIL pre_rst_count got %0d want 1", cnt);
      end
      line(1'b0, 1'b0);
      line(1'b0, 1'b1);
      line(1'b0, 1'b1);
      rst = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || cnt !== 5'd0 || out_data !== '0) begin
         errors++; $display("FAIL mid_rst got %b/%0d/%h want 0/0/0",
                            out_valid, cnt, out_data);
      end
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2 * BT) @(negedge clk);
      checks++;
      if (fe_n != f0 || pe_n != p0 || cnt !== 5'd0) begin
         errors++; $display("FAIL post_rst got %0d/%0d/%0d want 0/0/0",
                            fe_n - f0, pe_n - p0, cnt);
      end
      send_frame(1'b0, 8'hC3, -1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checks++;
      if (cnt !== 5'd1) begin
         errors++; $display("FAIL c3_count got %0d want 1", cnt);
      end
      drain(1'b0, done);
      checks++;
      if (!done) begin
         errors++; $display("FAIL c3_drain got %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_parity();
      test_break();
      test_bad_stop();
      test_glitch_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated show-ahead receive FIFO. It is the successor to the fixed 8N1 receive path that feeds Image_Processor from the host link. It adds configurable data width, parity, stop-bit count and buffer depth, plus error detection and overflow reporting. It sits between the rx pin and the JPEG byte consumer, which drains it through a valid/ready handshake.

Parameters:
- CLK_FREQ, 10_000_000: clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in baud. BIT_TICKS = CLK_FREQ/BAUD_RATE (integer division; 86 at defaults). Elaboration error if BIT_TICKS < 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first on the line.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: receive FIFO entries, power of two, at least 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- rx, input, 1: serial line, idle high, asynchronous to clk.
- out_data, output, DATA_BITS: FIFO head byte; see the optional feature for its width when that is enabled.
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts the head entry.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current number of entries.
- frame_err, output, 1: one-cycle pulse on a bad stop bit.
- parity_err, output, 1: one-cycle pulse on a parity mismatch.
- overflow, output, 1: sticky; set when a good frame is dropped because the FIFO is full.
- clr_overflow, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (rst=0) values:
  - out_valid=0, out_data=0, fifo_count=0, all error outputs 0.
  - FSM in IDLE, rx synchroniser stages at 1, FIFO pointers at 0.
- rx passes through a 2-flop synchroniser (rxs). A falling edge is rxs=0 while the previous rxs=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, load the bit timer with BIT_TICKS/2 and go to START.
- START: sample rxs when the timer expires.
  - rxs=0: reload the timer with BIT_TICKS and go to DATA.
  - rxs=1: treat as a glitch and return to IDLE with no error.
- DATA: sample one bit every BIT_TICKS at the bit centre into shift register bit index n (LSB first). After DATA_BITS samples, go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: sample the parity bit. Odd parity requires XOR(data, pbit)=1; even parity requires it to be 0. Latch the mismatch.
- STOP: sample STOP_BITS bits, each BIT_TICKS apart.
  - Any sampled 0 pulses frame_err the cycle after the sample. The frame is discarded and the FSM returns to IDLE immediately.
  - IDLE re-arms only on a fresh 1→0 edge, so a break (held 0) produces exactly one frame_err.
  - If all stop bits are good but a parity mismatch was latched, pulse parity_err and discard the frame.
  - If all stop bits are good and parity is good, push the byte. The frame_err/parity_err pulses are aligned to this same cycle.
- Latency: a pushed byte appears with out_valid=1 exactly one cycle after the final stop-bit sample, provided the FIFO was empty.
- FIFO (show-ahead):
  - out_data always presents the head entry; it is undefined-but-stable when empty (holds the last value).
  - Pop occurs when out_valid && out_ready.
  - When full, a push is accepted only if a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set. Data already in the FIFO is never overwritten.
  - Simultaneous push and pop when non-full leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count reaches FIFO_DEPTH at full.
- overflow stays set until clr_overflow=1 or reset. If a clear and a new overflow occur in the same cycle, set wins.
- Asserting reset mid-frame aborts the frame, empties the FIFO and emits no pulses. After release, the receiver waits for the next falling edge.

Optional Feature:
- Macro UART_RX_ERR_TAG_EN.
- When defined:
  - out_data widens to DATA_BITS+2, laid out as {frame_err_tag, parity_err_tag, data}.
  - Frames with parity or frame errors are pushed with their tag bits set rather than discarded.
  - The frame_err/parity_err pulses still fire.
- When undefined: out_data is DATA_BITS wide and errored frames are discarded as described above.

Test Plan:
- Defaults (BIT_TICKS=86): send 0xA5 in 8N1 with out_ready=0. Expect out_valid to rise 1 cycle after the stop-bit sample, out_data=0xA5, fifo_count=1, no error pulses.
- Send 17 bytes 0x00..0x10 with out_ready=0 (FIFO_DEPTH=16). Expect fifo_count=16 and overflow=1. Draining returns 0x00..0x0F in order; 0x10 is lost. Pulse clr_overflow, then expect overflow=0.
- PARITY=2: send 0x03 with parity bit 1. Expect one parity_err pulse and fifo_count unchanged. Resend 0x03 with parity bit 0 and expect it accepted.
- Hold rx low for 3 frame times after a start bit. Expect exactly one frame_err pulse, no push, and the next valid byte 0x5A received correctly.
- Drive a 10-cycle low glitch on rx. Expect a return to IDLE with no pulse and no push. Then assert rst low mid-frame: expect out_valid=0, fifo_count=0, and the following byte 0xC3 received correctly.
- With UART_RX_ERR_TAG_EN: send 0x7E with a bad stop bit. Expect the entry out_data={1,0,0x7E}, the frame_err pulse, and fifo_count=1.
